fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Fetch-address generator and I-cache front end (IF0/IF1) that feeds the fetch buffer. It holds the fetch PC and issues one I-cache request per fetch group of up to two aligned instructions. It returns the 64-bit group with pc/npc/flag/predictor metadata/excp_arg/plv, and redirects on backend flush or predicted-taken branch.

## Interface
- RESET_PC, 32'h1C00_0000, PC loaded at reset.
- ADEF_EXCP, 16'h9000, excp_arg for a misaligned PC: bit15 = exception valid, [14:9] = ecode 0x08, [8:0] = esubcode 0.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  backend redirect; highest priority after reset.
- redirect_pc  in  32  target when flush=1.
- stall_in  in  1  fetch buffer full or pipeline stall; the group is not consumed.
- cur_plv  in  2  current privilege level.
- bp_taken  in  1  predictor hit for the current fetch pc; combinational on pc_q.
- bp_slot  in  1  taken slot: 0 = pc, 1 = pc+4.
- bp_target  in  32  predicted target.
- bp_pre  in  64  predictor metadata, passed through.
- ic_req  out  1  I-cache request valid.
- ic_addr  out  32  request address {pc[31:3],3'b000}.
- ic_addr_ok  in  1  request accepted this cycle.
- ic_data_ok  in  1  data return this cycle.
- ic_rdata  in  64  [31:0] = word at addr, [63:32] = addr+4.
- icache_valid  out  1  group valid toward the fetch buffer.
- pc  out  32  PC of first valid instruction.
- npc  out  32  next fetch PC of this group.
- irin  out  64  instruction(s); [31:0] = slot at pc.
- flag  out  1  1 = two instructions valid, 0 = one.
- pre  out  64  registered bp_pre.
- excp_arg  out  16  exception argument; 0 if none.
- plv  out  2  plv latched at request.

## Operation
- State machine states: REQ, WAIT, HOLD, DISCARD.
- REQ:
  - ic_req=1 while pc_q is aligned.
  - On ic_addr_ok: latch pc, npc, flag, pre, plv; advance pc_q to npc; go to WAIT.
  - pc_q[1:0]≠0: no request. Go directly to HOLD with irin=0, flag=0, excp_arg=ADEF_EXCP.
- Sequential npc:
  - pc_q[2]=0 → pc_q+8, flag=1.
  - pc_q[2]=1 → pc_q+4, flag=0; irin[31:0] is taken from ic_rdata[63:32].
- Prediction:
  - bp_taken with bp_slot=0 → npc=bp_target, flag=0.
  - bp_taken with bp_slot=1 and pc_q[2]=0 → npc=bp_target, flag=1.
  - bp_slot=1 with pc_q[2]=1 is ignored.
- WAIT: on ic_data_ok capture irin and go to HOLD.
- HOLD:
  - icache_valid=1.
  - If !stall_in the group is consumed: go to REQ. The new request may be issued in the same cycle.
  - If stall_in: all outputs held stable.
- flush:
  - pc_q ← redirect_pc and icache_valid ← 0 next cycle.
  - From REQ (no address accepted) or HOLD → REQ.
  - From WAIT, or from REQ with ic_addr_ok in the same cycle → DISCARD.
- DISCARD: wait for ic_data_ok, drop the data, then go to REQ. A further flush while in DISCARD only updates pc_q.
- Only one request is outstanding at a time. Address arithmetic is mod 2^32; wrap is legal.

## Timing
- Reset values:
  - pc_q=RESET_PC; state REQ.
  - icache_valid=0, ic_req=0 during reset cycle, flag=0, pc=0, npc=0, irin=0, pre=0, excp_arg=0, plv=0.
- Latency: addr_ok to icache_valid is 1 cycle after ic_data_ok. A zero-wait cache gives a group every 2 cycles: addr_ok at t, data_ok at t+1, valid at t+2.
- ic_req and ic_addr are stable until ic_addr_ok.
- Simultaneous events:
  - flush beats stall_in.
  - flush and ic_data_ok in WAIT: data dropped, state → REQ directly.
  - Reset mid-transaction: state → REQ. Any later ic_data_ok is ignored, because REQ does not accept data.

## Structure
- Shared package holds:
  - RESET_PC and the ecode/esubcode constants (ADEF=0x08).
  - the excp_arg field layout.
  - the fetch FSM state enum.
- Natural sub-module: fetch_npc_calc, combinational. Inputs pc_q and bp_*; outputs npc and flag.

## Test plan
- Reset then zero-wait cache returning 64'h00000002_00000001 → first group pc=1C000000, flag=1, npc=1C000008, irin=64'h00000002_00000001; next request at 1C000008.
- flush redirect_pc=1C000104 → ic_addr=1C000100, flag=0, irin[31:0]=ic_rdata[63:32], npc=1C000108.
- bp_taken=1, bp_slot=0, bp_target=1C000200 at pc 1C000010 → flag=0, npc=1C000200; next ic_addr=1C000200.
- flush during WAIT, data_ok two cycles later → no icache_valid for the stale data; first valid group is at redirect_pc.
- stall_in held 5 cycles in HOLD → all outputs constant, ic_req=0; group consumed on the first cycle with stall_in=0.
- flush redirect_pc=1C000002 → no ic_req; icache_valid=1, excp_arg=16'h9000, irin=0, flag=0.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants, exception-argument layout and fetch FSM states for the
// IF0/IF1 fetch-address generator.
package fetch_pc_gen_pkg;

  localparam logic [31:0] RESET_PC      = 32'h1C00_0000;
  localparam logic [5:0]  ECODE_ADEF    = 6'h08;
  localparam logic [8:0]  ESUBCODE_ADEF = 9'h000;

  typedef struct packed {
    logic       valid;
    logic [5:0] ecode;
    logic [8:0] esubcode;
  } excp_arg_t;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_DISCARD
  } fetch_state_e;

  function automatic excp_arg_t make_excp(input logic [5:0] ecode,
                                          input logic [8:0] esubcode);
    excp_arg_t e;
    e.valid    = 1'b1;
    e.ecode    = ecode;
    e.esubcode = esubcode;
    return e;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_npc_calc.sv
// Next-fetch-PC and group-width selection from the current fetch PC and
// the branch predictor's verdict for it.
module fetch_npc_calc
  import fetch_pc_gen_pkg::*;
(
  input  logic [31:0] pc_q,
  input  logic        bp_taken,
  input  logic        bp_slot,
  input  logic [31:0] bp_target,
  output logic [31:0] npc,
  output logic        flag
);

  always_comb begin
    npc  = pc_q[2] ? (pc_q + 32'd4) : (pc_q + 32'd8);
    flag = ~pc_q[2];
    // A taken slot-1 prediction only makes sense when the group holds two slots.
    if (bp_taken) begin
      if (!bp_slot) begin
        npc  = bp_target;
        flag = 1'b0;
      end else if (!pc_q[2]) begin
        npc  = bp_target;
        flag = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register and I-cache request/response FSM; presents one fetch
// group at a time to the fetch buffer.
//
//   state      | meaning
//   FS_REQ     | fetch PC ready, request offered to the I-cache
//   FS_WAIT    | address accepted, waiting for data
//   FS_HOLD    | group valid toward the fetch buffer
//   FS_DISCARD | redirected while a request was in flight; drop its data
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        stall_in,
  input  logic [1:0]  cur_plv,
  input  logic        bp_taken,
  input  logic        bp_slot,
  input  logic [31:0] bp_target,
  input  logic [63:0] bp_pre,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_addr_ok,
  input  logic        ic_data_ok,
  input  logic [63:0] ic_rdata,
  output logic        icache_valid,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [63:0] irin,
  output logic        flag,
  output logic [63:0] pre,
  output logic [15:0] excp_arg,
  output logic [1:0]  plv
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  grp_pc_q, grp_pc_d;
  logic [31:0]  grp_npc_q, grp_npc_d;
  logic         flag_q, flag_d;
  logic [63:0]  irin_q, irin_d;
  logic [63:0]  pre_q, pre_d;
  excp_arg_t    excp_q, excp_d;
  logic [1:0]   plv_q, plv_d;

  logic [31:0]  calc_npc;
  logic         calc_flag;
  logic         aligned;
  logic         can_issue;
  logic         accepted;

  fetch_npc_calc u_npc_calc (
    .pc_q      (pc_q),
    .bp_taken  (bp_taken),
    .bp_slot   (bp_slot),
    .bp_target (bp_target),
    .npc       (calc_npc),
    .flag      (calc_flag)
  );

  // A consumed HOLD group may hand over to the next request in the same cycle.
  assign aligned   = (pc_q[1:0] == 2'b00);
  assign can_issue = (state_q == FS_REQ) || ((state_q == FS_HOLD) && !stall_in);
  assign ic_req    = rstn && can_issue && aligned;
  assign ic_addr   = {pc_q[31:3], 3'b000};
  assign accepted  = ic_req && ic_addr_ok;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    grp_pc_d  = grp_pc_q;
    grp_npc_d = grp_npc_q;
    flag_d    = flag_q;
    irin_d    = irin_q;
    pre_d     = pre_q;
    excp_d    = excp_q;
    plv_d     = plv_q;

    if (flush) begin
      pc_d = redirect_pc;
      case (state_q)
        FS_WAIT, FS_DISCARD: state_d = ic_data_ok ? FS_REQ : FS_DISCARD;
        default:             state_d = accepted ? FS_DISCARD : FS_REQ;
      endcase
    end else begin
      case (state_q)
        FS_REQ, FS_HOLD: begin
          if (can_issue) begin
            if (!aligned) begin
              grp_pc_d  = pc_q;
              grp_npc_d = pc_q;
              flag_d    = 1'b0;
              irin_d    = '0;
              pre_d     = bp_pre;
              plv_d     = cur_plv;
              excp_d    = make_excp(ECODE_ADEF, ESUBCODE_ADEF);
              state_d   = FS_HOLD;
            end else if (accepted) begin
              grp_pc_d  = pc_q;
              grp_npc_d = calc_npc;
              flag_d    = calc_flag;
              pre_d     = bp_pre;
              plv_d     = cur_plv;
              excp_d    = '0;
              pc_d      = calc_npc;
              state_d   = FS_WAIT;
            end else begin
              state_d   = FS_REQ;
            end
          end
        end
        FS_WAIT: begin
          if (ic_data_ok) begin
            // An odd-word PC fetches only the upper slot of the aligned pair.
            irin_d  = grp_pc_q[2] ? {32'h0, ic_rdata[63:32]} : ic_rdata;
            state_d = FS_HOLD;
          end
        end
        FS_DISCARD: begin
          if (ic_data_ok) state_d = FS_REQ;
        end
        default: state_d = FS_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= FS_REQ;
      pc_q      <= RESET_PC;
      grp_pc_q  <= '0;
      grp_npc_q <= '0;
      flag_q    <= 1'b0;
      irin_q    <= '0;
      pre_q     <= '0;
      excp_q    <= '0;
      plv_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      grp_pc_q  <= grp_pc_d;
      grp_npc_q <= grp_npc_d;
      flag_q    <= flag_d;
      irin_q    <= irin_d;
      pre_q     <= pre_d;
      excp_q    <= excp_d;
      plv_q     <= plv_d;
    end
  end

  assign icache_valid = (state_q == FS_HOLD);
  assign pc           = grp_pc_q;
  assign npc          = grp_npc_q;
  assign irin         = irin_q;
  assign flag         = flag_q;
  assign pre          = pre_q;
  assign excp_arg     = excp_q;
  assign plv          = plv_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a small I-cache responder with a
// configurable data latency plus scenario tasks with hand-computed results.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rstn, flush, stall_in, bp_taken, bp_slot;
  logic [31:0] redirect_pc, bp_target;
  logic [1:0]  cur_plv;
  logic [63:0] bp_pre;
  logic        ic_req, ic_addr_ok, ic_data_ok, icache_valid, flag;
  logic [31:0] ic_addr, pc, npc;
  logic [63:0] ic_rdata, irin, pre;
  logic [15:0] excp_arg;
  logic [1:0]  plv;

  int          n_cmp = 0;
  int          n_err = 0;
  int          data_lat = 1;
  int          dcnt = 0;
  logic        auto_en = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_match = 32'h0;
  logic [63:0] rdata_val = 64'h0;
  bit          got;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk(clk), .rstn(rstn), .flush(flush), .redirect_pc(redirect_pc),
    .stall_in(stall_in), .cur_plv(cur_plv), .bp_taken(bp_taken),
    .bp_slot(bp_slot), .bp_target(bp_target), .bp_pre(bp_pre),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_addr_ok(ic_addr_ok),
    .ic_data_ok(ic_data_ok), .ic_rdata(ic_rdata),
    .icache_valid(icache_valid), .pc(pc), .npc(npc), .irin(irin),
    .flag(flag), .pre(pre), .excp_arg(excp_arg), .plv(plv)
  );

  // I-cache model: accepts every request at once, returns data data_lat cycles later.
  assign ic_addr_ok = auto_en & ic_req;
  assign ic_data_ok = (dcnt == 1);
  assign ic_rdata   = rdata_val;
  assign bp_taken   = bp_en & (ic_addr == bp_match);

  always @(posedge clk) begin
    if (!rstn)                     dcnt <= 0;
    else if (ic_req && ic_addr_ok) dcnt <= data_lat;
    else if (dcnt > 0)             dcnt <= dcnt - 1;
  end

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (icache_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ic_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_flush(input logic [31:0] target);
    @(posedge clk); #1;
    flush = 1'b1; redirect_pc = target;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; stall_in = 1'b0; redirect_pc = '0;
    cur_plv = 2'd0; bp_slot = 1'b0; bp_target = '0; bp_pre = '0;
    auto_en = 1'b1; data_lat = 1; rdata_val = 64'h00000002_00000001;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b0) begin n_err++; $display("FAIL rst_ic_req got=%b exp=0", ic_req); end
    n_cmp++; if (icache_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", icache_valid); end
    n_cmp++; if (pc !== 32'h0 || npc !== 32'h0) begin n_err++; $display("FAIL rst_pc_npc got=%h/%h exp=0/0", pc, npc); end
    n_cmp++; if (irin !== 64'h0 || flag !== 1'b0) begin n_err++; $display("FAIL rst_irin_flag got=%h/%b exp=0/0", irin, flag); end
    n_cmp++; if (pre !== 64'h0 || excp_arg !== 16'h0 || plv !== 2'd0) begin n_err++; $display("FAIL rst_pre_excp_plv got=%h/%h/%h exp=0", pre, excp_arg, plv); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_sequential();
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b1 || ic_addr !== 32'h1C000000) begin n_err++; $display("FAIL seq_first_req got=%b/%h exp=1/1c000000", ic_req, ic_addr); end
    wait_valid(10, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL seq_valid_timeout got=0 exp=1"); end
    n_cmp++; if (pc !== 32'h1C000000) begin n_err++; $display("FAIL seq_pc got=%h exp=1c000000", pc); end
    n_cmp++; if (flag !== 1'b1 || npc !== 32'h1C000008) begin n_err++; $display("FAIL seq_flag_npc got=%b/%h exp=1/1c000008", flag, npc); end
    n_cmp++; if (irin !== 64'h00000002_00000001) begin n_err++; $display("FAIL seq_irin got=%h exp=0000000200000001", irin); end
    n_cmp++; if (ic_req !== 1'b1 || ic_addr !== 32'h1C000008) begin n_err++; $display("FAIL seq_next_req got=%b/%h exp=1/1c000008", ic_req, ic_addr); end
  endtask

  task automatic test_flush_odd();
    rdata_val = 64'hBBBB0002_AAAA0001;
    do_flush(32'h1C000104);
    wait_req(10, got);
    n_cmp++; if (!got || ic_addr !== 32'h1C000100) begin n_err++; $display("FAIL odd_addr got=%b/%h exp=1/1c000100", got, ic_addr); end
    wait_valid(10, got);
    n_cmp++; if (!got || pc !== 32'h1C000104) begin n_err++; $display("FAIL odd_pc got=%b/%h exp=1/1c000104", got, pc); end
    n_cmp++; if (flag !== 1'b0 || npc !== 32'h1C000108) begin n_err++; $display("FAIL odd_flag_npc got=%b/%h exp=0/1c000108", flag, npc); end
    n_cmp++; if (irin[31:0] !== 32'hBBBB0002) begin n_err++; $display("FAIL odd_irin got=%h exp=bbbb0002", irin[31:0]); end
  endtask

  task automatic test_predict();
    cur_plv = 2'd3; bp_pre = 64'hDEADBEEF_01234567;
    bp_en = 1'b1; bp_match = 32'h1C000010; bp_slot = 1'b0; bp_target = 32'h1C000200;
    do_flush(32'h1C000010);
    wait_valid(10, got);
    n_cmp++; if (!got || pc !== 32'h1C000010) begin n_err++; $display("FAIL bp0_pc got=%b/%h exp=1/1c000010", got, pc); end
    n_cmp++; if (flag !== 1'b0 || npc !== 32'h1C000200) begin n_err++; $display("FAIL bp0_flag_npc got=%b/%h exp=0/1c000200", flag, npc); end
    n_cmp++; if (pre !== 64'hDEADBEEF_01234567 || plv !== 2'd3) begin n_err++; $display("FAIL bp0_pre_plv got=%h/%h exp=deadbeef01234567/3", pre, plv); end
    n_cmp++; if (ic_req !== 1'b1 || ic_addr !== 32'h1C000200) begin n_err++; $display("FAIL bp0_next_addr got=%b/%h exp=1/1c000200", ic_req, ic_addr); end

    bp_match = 32'h1C000020; bp_slot = 1'b1; bp_target = 32'h1C000300;
    do_flush(32'h1C000020);
    wait_valid(10, got);
    n_cmp++; if (!got || flag !== 1'b1 || npc !== 32'h1C000300) begin n_err++; $display("FAIL bp1_even got=%b/%b/%h exp=1/1/1c000300", got, flag, npc); end

    do_flush(32'h1C000024);
    wait_valid(10, got);
    n_cmp++; if (!got || flag !== 1'b0 || npc !== 32'h1C000028) begin n_err++; $display("FAIL bp1_odd_ignored got=%b/%b/%h exp=1/0/1c000028", got, flag, npc); end
    bp_en = 1'b0;
  endtask

  task automatic test_flush_in_wait();
    data_lat = 3;
    do_flush(32'h1C000400);
    wait_req(10, got);
    n_cmp++; if (!got || ic_addr !== 32'h1C000400) begin n_err++; $display("FAIL fw_first_req got=%b/%h exp=1/1c000400", got, ic_addr); end
    @(posedge clk); #1;
    flush = 1'b1; redirect_pc = 32'h1C000500;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b0 || icache_valid !== 1'b0) begin n_err++; $display("FAIL fw_discard got=%b/%b exp=0/0", ic_req, icache_valid); end
    wait_valid(20, got);
    n_cmp++; if (!got || pc !== 32'h1C000500) begin n_err++; $display("FAIL fw_first_valid_pc got=%b/%h exp=1/1c000500", got, pc); end

    data_lat = 1;
    do_flush(32'h1C000800);
    wait_req(10, got);
    @(posedge clk); #1;
    flush = 1'b1; redirect_pc = 32'h1C000900;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (!got || ic_req !== 1'b1 || ic_addr !== 32'h1C000900 || icache_valid !== 1'b0) begin n_err++; $display("FAIL fw_dataok_same got=%b/%b/%h/%b exp=1/1/1c000900/0", got, ic_req, ic_addr, icache_valid); end
  endtask

  task automatic test_stall();
    stall_in = 1'b1; rdata_val = 64'h22222222_11111111;
    do_flush(32'h1C000600);
    wait_valid(10, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL st_valid_timeout got=0 exp=1"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (icache_valid !== 1'b1 || ic_req !== 1'b0 || pc !== 32'h1C000600 || npc !== 32'h1C000608 ||
          flag !== 1'b1 || irin !== 64'h22222222_11111111 || excp_arg !== 16'h0) begin
        n_err++;
        $display("FAIL st_hold[%0d] got v=%b req=%b pc=%h npc=%h f=%b irin=%h exp v=1 req=0 pc=1c000600 npc=1c000608 f=1 irin=2222222211111111",
                 i, icache_valid, ic_req, pc, npc, flag, irin);
      end
    end
    @(posedge clk); #1;
    stall_in = 1'b0;
    @(negedge clk);
    n_cmp++; if (icache_valid !== 1'b1 || ic_req !== 1'b1 || ic_addr !== 32'h1C000608) begin n_err++; $display("FAIL st_release got=%b/%b/%h exp=1/1/1c000608", icache_valid, ic_req, ic_addr); end
    @(negedge clk);
    n_cmp++; if (icache_valid !== 1'b0) begin n_err++; $display("FAIL st_consumed got=%b exp=0", icache_valid); end
  endtask

  task automatic test_misaligned();
    do_flush(32'h1C000002);
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b0) begin n_err++; $display("FAIL mis_no_req got=%b exp=0", ic_req); end
    wait_valid(10, got);
    n_cmp++; if (!got || excp_arg !== 16'h9000) begin n_err++; $display("FAIL mis_excp got=%b/%h exp=1/9000", got, excp_arg); end
    n_cmp++; if (irin !== 64'h0 || flag !== 1'b0 || pc !== 32'h1C000002) begin n_err++; $display("FAIL mis_group got=%h/%b/%h exp=0/0/1c000002", irin, flag, pc); end
    n_cmp++; if (ic_req !== 1'b0) begin n_err++; $display("FAIL mis_hold_no_req got=%b exp=0", ic_req); end
    do_flush(32'h1C000700);
    wait_valid(10, got);
    n_cmp++; if (!got || excp_arg !== 16'h0 || pc !== 32'h1C000700) begin n_err++; $display("FAIL mis_recover got=%b/%h/%h exp=1/0000/1c000700", got, excp_arg, pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_flush_odd();
    test_predict();
    test_flush_in_wait();
    test_stall();
    test_misaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
